// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, default FIFO depth and pointer-width helper
package uart_pkg;

    localparam int UART_WIDTH      = 8;
    localparam int UART_FIFO_DEPTH = 16;

    // Pointer width needed to address 'depth' entries (at least one bit)
    function automatic int uart_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x WIDTH storage, one synchronous write port, one asynchronous read port
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH,
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int PW    = uart_ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with show-ahead read and sticky overflow (optional rts_n: UART_RX_FIFO_RTS_EN)
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH        = UART_WIDTH,
    parameter int DEPTH        = UART_FIFO_DEPTH,
    parameter int AFULL_THRESH = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_pulse,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
`ifdef UART_RX_FIFO_RTS_EN
    output logic                   rts_n,
`endif
    input  logic                   ovf_clr
);

    localparam int PW = uart_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop;

    // A write while full is still accepted when the head leaves in the same cycle
    always_comb begin
        pop  = rd_valid && rd_ready;
        push = wr_pulse && (!full || pop);
        drop = wr_pulse && !push;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A drop in the same cycle as a clear keeps the flag set
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Pointer, count and overflow registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    uart_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push && rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign count    = count_q;
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign overflow = ovf_q;

`ifdef UART_RX_FIFO_RTS_EN
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    logic rts_n_q;

    // Registered from the current level, so it follows count by one cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            rts_n_q <= 1'b0;
        end else begin
            rts_n_q <= (count_q >= AFULL_C);
        end
    end

    assign rts_n = rts_n_q;
`else
    logic unused_afull;
    assign unused_afull = |AFULL_THRESH;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] wr_data;
    logic             wr_pulse;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ovf_clr;
`ifdef UART_RX_FIFO_RTS_EN
    logic             rts_n;
`endif

    uart_rx_fifo #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_pulse (wr_pulse),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
`ifdef UART_RX_FIFO_RTS_EN
        .rts_n    (rts_n),
`endif
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] mq[$];
    logic             m_ovf = 1'b0;
    logic             m_rts = 1'b0;
    int               n_pushed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare all outputs with the model, apply one clock of stimulus, advance the model
    task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rdy, input logic clr);
        int   sz;
        logic do_pop, do_push;
        wr_pulse = wr;
        wr_data  = d;
        rd_ready = rdy;
        ovf_clr  = clr;
        sz = mq.size();
        check("count", 32'(count), sz);
        check("empty", 32'(empty), 32'(sz == 0));
        check("full", 32'(full), 32'(sz == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(sz != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (sz != 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
`ifdef UART_RX_FIFO_RTS_EN
        check("rts_n", 32'(rts_n), 32'(m_rts));
`endif
        do_pop  = (sz != 0) && rdy;
        do_push = wr && ((sz < DEPTH) || do_pop);
        @(posedge clk);
        #1;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            mq.push_back(d);
            n_pushed++;
        end
        if (wr && !do_push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_rts = (sz >= AFULL);
        wr_pulse = 1'b0;
        rd_ready = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    // One reset edge with a write and a read pending, both of which must be ignored
    task automatic do_reset();
        rst      = 1'b0;
        wr_pulse = 1'b1;
        wr_data  = 8'h77;
        rd_ready = 1'b1;
        ovf_clr  = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        wr_pulse = 1'b0;
        rd_ready = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_rts = 1'b0;
    endtask

    initial begin
        int sent;
        int budget;
        rst = 1'b0; wr_pulse = 1'b0; wr_data = '0; rd_ready = 1'b0; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state and single pass-through
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("pass_rd_data", 32'(rd_data), 32'h0000_00A5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);

        // Overflow, clear, and set-beats-clear
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Pop and push while full, then drain
        step(1'b1, 8'h55, 1'b1, 1'b0);
        check("pp_count", 32'(count), 32'd16);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(rd_data), 32'h01);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("drain_empty", 32'(empty), 32'd1);

        // Wrap-around: 40 bytes with random ready, never overflowing
        sent = 0;
        n_pushed = 0;
        budget = 0;
        while (sent < 40 && budget < 2000) begin
            if (mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                step(1'b1, 8'(8'h10 + sent), 1'($urandom_range(0, 1)), 1'b0);
                sent++;
            end else begin
                step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            end
            budget++;
        end
        check("wrap_sent", sent, 32'd40);
        check("wrap_no_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Fully random traffic including drops and clears
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0));
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b1);

        // Reset mid-operation after 12 writes
        for (int i = 0; i < AFULL; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_RTS_EN
        check("rts_high", 32'(rts_n), 32'd1);
`endif
        for (int i = 0; i < 6; i++) step(1'b1, 8'hC0, 1'b0, 1'b0);
        do_reset();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_RTS_EN
        check("rst_rts", 32'(rts_n), 32'd0);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each byte presented with the receiver's single-cycle done pulse into a circular FIFO.
- Presents bytes to the consumer through a show-ahead valid/ready interface.
- Reports fill level, full/empty status and a sticky overflow flag.

Parameters:
- WIDTH, 8, data bits per entry; matches the receiver data width.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- AFULL_THRESH, 12, fill level at or above which the flow-control output asserts (optional feature only); legal range 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low; clears the block on a rising clk edge while low.
- wr_data  input  WIDTH  byte from the receiver; valid only in the cycle wr_pulse is high.
- wr_pulse  input  1  one-cycle write strobe (receiver done pulse); no backpressure is possible.
- rd_data  output  WIDTH  head entry; valid while rd_valid is high.
- rd_valid  output  1  FIFO not empty.
- rd_ready  input  1  consumer accepts the head entry.
- count  output  $clog2(DEPTH)+1  current number of stored entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  one-cycle clear for overflow.
- rts_n  output  1  flow control, active-low "ready to send"; present only with UART_RX_FIFO_RTS_EN.

Behaviour:
- Reset (rst low at a clock edge):
  - Write and read pointers = 0; count = 0; overflow = 0.
  - Therefore empty = 1, full = 0, rd_valid = 0.
  - rts_n = 0 when the optional feature is present.
  - Storage contents are not reset.
  - Reset mid-operation discards all stored entries, and any write or read in that cycle is ignored.
- Storage and pointers:
  - DEPTH x WIDTH register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately, so full and empty are unambiguous.
- Push: occurs when wr_pulse = 1 and (full = 0 or a pop occurs in the same cycle).
  - wr_data is written at the write pointer, and the write pointer increments.
- Pop: occurs when rd_valid = 1 and rd_ready = 1.
  - The read pointer increments.
  - rd_ready while empty has no effect.
- Show-ahead read:
  - rd_data is driven combinationally from storage at the read pointer.
  - A byte pushed in cycle N appears on rd_data with rd_valid = 1 in cycle N+1 (latency 1).
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
- Simultaneous push and pop:
  - When full: the write is accepted, count stays at DEPTH, no overflow.
  - When empty: pop is impossible, so only the push occurs.
- Overflow:
  - wr_pulse while full with no pop: wr_data is dropped, pointers are unchanged, overflow is set to 1.
  - overflow holds until ovf_clr.
  - If ovf_clr and a new drop occur in the same cycle, set wins and overflow stays 1.
- full, empty and rd_valid are decoded combinationally from count.

Optional Feature:
- Macro: UART_RX_FIFO_RTS_EN.
- Defined:
  - rts_n port exists and is registered.
  - rts_n is 1 (stop sender) on the cycle after count becomes >= AFULL_THRESH.
  - rts_n returns to 0 on the cycle after count falls below AFULL_THRESH.
  - No hysteresis.
- Not defined: the port and its logic are absent, and AFULL_THRESH is unused.

Decomposition:
- Package uart_pkg holds:
  - UART_WIDTH default (8).
  - Default FIFO depth (16).
  - A function returning pointer width for a given depth.
- Optional sub-module uart_fifo_mem: plain DEPTH x WIDTH storage with one synchronous write port and one asynchronous read port.
- Pointer, count, flag and overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset and single pass-through:
  - Stimulus: after reset, one wr_pulse with 0xA5.
  - Required: next cycle rd_valid = 1, rd_data = 0xA5, count = 1; a pop with rd_ready returns empty = 1, count = 0.
- Fill to full, no reads:
  - Stimulus: 16 writes 0x00..0x0F with rd_ready = 0.
  - Required: full = 1, count = 16; reading back yields 0x00..0x0F in order.
- Overflow:
  - Stimulus: when full, write 0xEE.
  - Required: overflow = 1, count stays 16, 0xEE is never read.
  - Stimulus: ovf_clr.
  - Required: overflow = 0 the next cycle.
- Pop and push while full:
  - Stimulus: full holding 0x00..0x0F; same-cycle pop and write 0x55.
  - Required: count = 16, overflow = 0, drain order 0x01..0x0F then 0x55.
- Wrap-around:
  - Stimulus: 40 bytes (0x10+i) with randomised rd_ready, never overflowing.
  - Required: output sequence identical to input, pointers wrapped at least twice.
- Reset mid-operation, with UART_RX_FIFO_RTS_EN:
  - Stimulus: write 12 bytes.
  - Required: rts_n = 1 the cycle after count reaches 12.
  - Stimulus: assert rst low for one edge.
  - Required: count = 0, empty = 1, overflow = 0, rts_n = 0.
